// File: rtl/fp_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : fp_pkg                                                        |
// | Purpose  : FP32 field constants, fflags bit indices, operand classifiers |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package fp_pkg;

  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  localparam int FLAGS_W = 5;
  localparam int FLG_NV  = 4;
  localparam int FLG_DZ  = 3;
  localparam int FLG_OF  = 2;
  localparam int FLG_UF  = 1;
  localparam int FLG_NX  = 0;

  // Classifiers take the magnitude bits only; the sign never affects the class.
  function automatic logic is_nan(input logic [30:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(input logic [30:0] x);
    return is_nan(x) && !x[22];
  endfunction

  function automatic logic is_inf(input logic [30:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [30:0] x);
    return x == 31'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fmul_unit_core.sv
// +--------------------------------------------------------------------------+
// | Module   : fmul_unit_core                                                |
// | Purpose  : Combinational FP32 multiply, round-to-nearest-even            |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module fmul_unit_core
  import fp_pkg::*;
(
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out,
  output logic        inexact
);

  logic               w_sign;
  logic [7:0]         w_ea;
  logic [7:0]         w_eb;
  logic [23:0]        w_ma;
  logic [23:0]        w_mb;
  logic [47:0]        w_prod;
  logic [5:0]         w_lz;
  logic [47:0]        w_norm;
  logic signed [10:0] w_exp;
  logic signed [10:0] w_rsw;
  logic [5:0]         w_rs;
  logic [47:0]        w_shr;
  logic               w_lost;
  logic               w_ovf;
  logic [7:0]         w_ebase;
  logic               w_guard;
  logic               w_sticky;
  logic               w_rnd;
  logic [30:0]        w_sum;

  assign w_sign = in1[31] ^ in2[31];
  assign w_ea   = (in1[30:23] == 8'd0) ? 8'd1 : in1[30:23];
  assign w_eb   = (in2[30:23] == 8'd0) ? 8'd1 : in2[30:23];
  assign w_ma   = {in1[30:23] != 8'd0, in1[22:0]};
  assign w_mb   = {in2[30:23] != 8'd0, in2[22:0]};
  assign w_prod = {24'd0, w_ma} * {24'd0, w_mb};

  always_comb begin
    w_lz = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (w_prod[i]) w_lz = 6'(47 - i);
    end
  end

  // Leading one moved to bit 47; a product with its MSB at bit 47 has biased
  // exponent ea + eb - 126.
  assign w_norm = w_prod << w_lz;
  assign w_exp  = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb})
                - 11'sd126 - $signed({5'b00000, w_lz});

  always_comb begin
    w_ebase = 8'd0;
    w_shr   = w_norm;
    w_lost  = 1'b0;
    w_rsw   = 11'sd0;
    w_rs    = 6'd0;
    w_ovf   = 1'b0;
    if (w_exp >= 11'sd255) begin
      w_ovf = 1'b1;
    end else if (w_exp >= 11'sd1) begin
      w_ebase = 8'(w_exp - 11'sd1);
    end else begin
      w_rsw  = 11'sd1 - w_exp;
      w_rs   = (w_rsw > 11'sd48) ? 6'd48 : w_rsw[5:0];
      w_shr  = w_norm >> w_rs;
      w_lost = ((w_shr << w_rs) != w_norm);
    end
  end

  assign w_guard  = w_shr[23];
  assign w_sticky = (|w_shr[22:0]) | w_lost;
  assign w_rnd    = w_guard & (w_sticky | w_shr[24]);
  // Hidden bit lands in the exponent field, so a rounding carry out of the
  // fraction bumps the exponent (and a subnormal can round up to normal).
  assign w_sum    = {w_ebase, 23'd0} + {7'd0, w_shr[47:24]} + {30'd0, w_rnd};

  always_comb begin
    out     = {w_sign, w_sum};
    inexact = w_guard | w_sticky;
    if (w_prod == 48'd0) begin
      out     = {w_sign, 31'd0};
      inexact = 1'b0;
    end else if (w_ovf) begin
      out     = {w_sign, EXP_MAX, 23'd0};
      inexact = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fmul_unit.sv
// +--------------------------------------------------------------------------+
// | Module   : fmul_unit                                                     |
// | Purpose  : Pipelined handshaked FP32 multiply unit with RISC-V fix-up    |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module fmul_unit #(
  parameter int LAT   = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_rd,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_rd,
  output logic [31:0]      wb_data,
  output logic [4:0]       wb_fflags,
  output logic [4:0]       fflags_acc,
  input  logic             fflags_clr
);

  import fp_pkg::*;

  logic               r_s1_valid;
  logic [31:0]        r_s1_rs1;
  logic [31:0]        r_s1_rs2;
  logic [TAG_W-1:0]   r_s1_rd;

  logic [31:0]        w_core_out;
  logic               w_core_inexact;
  logic [31:0]        w_fx_data;
  logic [FLAGS_W-1:0] w_fx_flags;
  logic               w_nan_any;
  logic               w_zinf;
  logic               w_sign;

  logic [LAT:2]       r_valid;
  logic [31:0]        r_data  [2:LAT];
  logic [4:0]         r_flags [2:LAT];
  logic [TAG_W-1:0]   r_rd    [2:LAT];

  logic [LAT:2]       w_en;
  logic               w_en1;
  logic               w_hs;
  logic [4:0]         r_acc;

  // Stage k may load when it is empty or its content moves on; that reduces
  // to "wb_ready, or some stage from k to the end is empty".
  always_comb begin : p_advance
    logic w_hole;
    w_hole = 1'b0;
    w_en   = '0;
    for (int k = LAT; k >= 2; k--) begin
      w_hole  = w_hole | ~r_valid[k];
      w_en[k] = wb_ready | w_hole;
    end
  end

  assign w_en1     = ~r_s1_valid | w_en[2];
  assign req_ready = w_en1 & ~flush;
  assign w_hs      = wb_valid & wb_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_rd    <= '0;
    end else begin
      if (flush)      r_s1_valid <= 1'b0;
      else if (w_en1) r_s1_valid <= req_valid;
      if (req_valid && req_ready) begin
        r_s1_rs1 <= req_rs1;
        r_s1_rs2 <= req_rs2;
        r_s1_rd  <= req_rd;
      end
    end
  end

  fmul_unit_core u_core (
    .in1     (r_s1_rs1),
    .in2     (r_s1_rs2),
    .out     (w_core_out),
    .inexact (w_core_inexact)
  );

  assign w_sign    = r_s1_rs1[31] ^ r_s1_rs2[31];
  assign w_nan_any = is_nan(r_s1_rs1[30:0]) | is_nan(r_s1_rs2[30:0]);
  assign w_zinf    = (is_zero(r_s1_rs1[30:0]) & is_inf(r_s1_rs2[30:0]))
                   | (is_inf(r_s1_rs1[30:0]) & is_zero(r_s1_rs2[30:0]));

  always_comb begin
    w_fx_data          = w_core_out;
    w_fx_flags         = '0;
    w_fx_flags[FLG_NV] = is_snan(r_s1_rs1[30:0]) | is_snan(r_s1_rs2[30:0]) | w_zinf;
    w_fx_flags[FLG_DZ] = 1'b0;
    w_fx_flags[FLG_UF] = 1'b0;
    if (w_nan_any || w_zinf) begin
      w_fx_data = CANON_NAN;
    end else if (is_inf(r_s1_rs1[30:0]) || is_inf(r_s1_rs2[30:0])) begin
      w_fx_data = {w_sign, EXP_MAX, 23'd0};
    end else if (is_zero(r_s1_rs1[30:0]) || is_zero(r_s1_rs2[30:0])) begin
      w_fx_data = {w_sign, 31'd0};
    end else begin
      w_fx_flags[FLG_OF] = (w_core_out[30:23] == EXP_MAX);
      w_fx_flags[FLG_NX] = w_core_inexact | (w_core_out[30:23] == EXP_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid[2] <= 1'b0;
      r_data[2]  <= '0;
      r_flags[2] <= '0;
      r_rd[2]    <= '0;
    end else begin
      if (flush)        r_valid[2] <= 1'b0;
      else if (w_en[2]) r_valid[2] <= r_s1_valid;
      if (w_en[2] && r_s1_valid) begin
        r_data[2]  <= w_fx_data;
        r_flags[2] <= w_fx_flags;
        r_rd[2]    <= r_s1_rd;
      end
    end
  end

  for (genvar k = 3; k <= LAT; k++) begin : g_delay
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_flags[k] <= '0;
        r_rd[k]    <= '0;
      end else begin
        if (flush)        r_valid[k] <= 1'b0;
        else if (w_en[k]) r_valid[k] <= r_valid[k-1];
        if (w_en[k] && r_valid[k-1]) begin
          r_data[k]  <= r_data[k-1];
          r_flags[k] <= r_flags[k-1];
          r_rd[k]    <= r_rd[k-1];
        end
      end
    end
  end

  assign wb_valid  = r_valid[LAT];
  assign wb_data   = r_data[LAT];
  assign wb_fflags = r_flags[LAT];
  assign wb_rd     = r_rd[LAT];

  // A clear coinciding with a handshake keeps that result's flags.
  always_ff @(posedge clk) begin
    if (rst)             r_acc <= '0;
    else if (fflags_clr) r_acc <= w_hs ? wb_fflags : 5'd0;
    else if (w_hs)       r_acc <= r_acc | wb_fflags;
  end

  assign fflags_acc = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_fmul_unit.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_fmul_unit                                                  |
// | Purpose  : Directed self-checking bench for fmul_unit (LAT=2)            |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fmul_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rd;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  wb_fflags;
  logic [4:0]  fflags_acc;
  logic        fflags_clr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] bp_b   [4];
  logic [31:0] bp_exp [4];

  fmul_unit #(.LAT(2), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .flush      (flush),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_fflags  (wb_fflags),
    .fflags_acc (fflags_acc),
    .fflags_clr (fflags_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    req_valid = 1'b1;
    req_rs1   = a;
    req_rs2   = b;
    req_rd    = rd;
    #1;
    check($sformatf("%s.req_ready", tag), {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_wb(input string tag, input logic [31:0] d, input logic [4:0] f,
                           input logic [4:0] rd);
    check($sformatf("%s.valid", tag), {31'd0, wb_valid}, 32'd1);
    check($sformatf("%s.data", tag), wb_data, d);
    check($sformatf("%s.fflags", tag), {27'd0, wb_fflags}, {27'd0, f});
    check($sformatf("%s.rd", tag), {27'd0, wb_rd}, {27'd0, rd});
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_rd     = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    flush      = 1'b0;
    wb_ready   = 1'b0;
    fflags_clr = 1'b0;
    bp_b[0] = 32'h4000_0000; bp_exp[0] = 32'h4080_0000;
    bp_b[1] = 32'h4040_0000; bp_exp[1] = 32'h40C0_0000;
    bp_b[2] = 32'h4080_0000; bp_exp[2] = 32'h4100_0000;
    bp_b[3] = 32'h40A0_0000; bp_exp[3] = 32'h4120_0000;

    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst.wb_fflags", {27'd0, wb_fflags}, 32'd0);
    check("rst.acc", {27'd0, fflags_acc}, 32'd0);
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);

    // 2.0 x 3.0 with latency check
    wb_ready = 1'b1;
    send("mul23", 32'h4000_0000, 32'h4040_0000, 5'd7);
    check("mul23.early_valid", {31'd0, wb_valid}, 32'd0);
    tick();
    expect_wb("mul23", 32'h40C0_0000, 5'h00, 5'd7);

    // invalid operations
    send("snan", 32'h3F80_0000, 32'h7F80_0001, 5'd1);
    tick();
    expect_wb("snan", 32'h7FC0_0000, 5'h10, 5'd1);
    send("zinf", 32'h0000_0000, 32'hFF80_0000, 5'd2);
    tick();
    expect_wb("zinf", 32'h7FC0_0000, 5'h10, 5'd2);
    tick();
    check("nv.drained", {31'd0, wb_valid}, 32'd0);
    check("nv.acc", {27'd0, fflags_acc}, 32'h10);
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    check("clr_alone.acc", {27'd0, fflags_acc}, 32'h00);

    // overflow and inexact
    send("ovf", 32'h7F00_0000, 32'h4000_0000, 5'd3);
    tick();
    expect_wb("ovf", 32'h7F80_0000, 5'h05, 5'd3);
    send("nx", 32'h3F80_0001, 32'h3F80_0001, 5'd4);
    tick();
    expect_wb("nx", 32'h3F80_0002, 5'h01, 5'd4);
    tick();
    check("ofnx.acc", {27'd0, fflags_acc}, 32'h05);

    // back-pressure: capacity LAT, then drain in order
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_rs1   = 32'h4000_0000;
      req_rs2   = bp_b[i];
      req_rd    = 5'(i + 1);
      #1;
      check($sformatf("bp.req_ready%0d", i), {31'd0, req_ready}, (i < 2) ? 32'd1 : 32'd0);
      tick();
    end
    expect_wb("bp.held", bp_exp[0], 5'h00, 5'd1);
    wb_ready = 1'b1;
    #1;
    check("bp.release_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_rs2 = bp_b[3];
    req_rd  = 5'd4;
    expect_wb("bp.r1", bp_exp[1], 5'h00, 5'd2);
    tick();
    req_valid = 1'b0;
    expect_wb("bp.r2", bp_exp[2], 5'h00, 5'd3);
    tick();
    expect_wb("bp.r3", bp_exp[3], 5'h00, 5'd4);
    tick();
    check("bp.drained", {31'd0, wb_valid}, 32'd0);

    // flush with two in flight and a coincident request
    wb_ready = 1'b0;
    send("fl.a", 32'h4000_0000, 32'h4000_0000, 5'd5);
    send("fl.b", 32'h4040_0000, 32'h4040_0000, 5'd6);
    check("fl.pre_valid", {31'd0, wb_valid}, 32'd1);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_rs1   = 32'h4000_0000;
    req_rs2   = 32'h4000_0000;
    req_rd    = 5'd8;
    #1;
    check("fl.req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("fl.valid_cleared", {31'd0, wb_valid}, 32'd0);
    wb_ready = 1'b1;
    tick();
    tick();
    check("fl.no_ghost", {31'd0, wb_valid}, 32'd0);
    check("fl.acc_kept", {27'd0, fflags_acc}, 32'h05);
    send("fl.next", 32'h4000_0000, 32'h4040_0000, 5'd9);
    tick();
    expect_wb("fl.next", 32'h40C0_0000, 5'h00, 5'd9);
    tick();
    check("fl.next_drained", {31'd0, wb_valid}, 32'd0);

    // clear coinciding with a handshake carrying NX
    send("clrhs", 32'h3F80_0001, 32'h3F80_0001, 5'd11);
    tick();
    expect_wb("clrhs", 32'h3F80_0002, 5'h01, 5'd11);
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    check("clrhs.acc", {27'd0, fflags_acc}, 32'h01);

    // reset mid-stream
    wb_ready = 1'b0;
    send("mr.a", 32'h4000_0000, 32'h4040_0000, 5'd12);
    send("mr.b", 32'h4040_0000, 32'h4040_0000, 5'd13);
    expect_wb("mr.pre", 32'h40C0_0000, 5'h00, 5'd12);
    rst       = 1'b1;
    flush     = 1'b1;
    req_valid = 1'b1;
    tick();
    check("mr.wb_valid", {31'd0, wb_valid}, 32'd0);
    check("mr.wb_data", wb_data, 32'd0);
    check("mr.wb_rd", {27'd0, wb_rd}, 32'd0);
    check("mr.wb_fflags", {27'd0, wb_fflags}, 32'd0);
    check("mr.acc", {27'd0, fflags_acc}, 32'd0);
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("mr.req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    tick();
    check("mr.no_output", {31'd0, wb_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
